crc4_frame_ctrl: RTL
====================

Name: crc4_frame_ctrl

Overview:
- Frame-level controller for the 4-bit CRC datapath. It takes an 8-bit byte stream under valid/ready and runs the 8-bit-parallel CRC-4 LFSR once per byte.
- Generate mode: forwards the payload and appends one CRC byte.
- Check mode: forwards the frame unchanged and reports pass/fail on the trailing CRC byte.
- Sits between a byte source and a byte sink, with a 1-deep registered output slice.

Parameters:
CNT_W, 16, width of the frame and error counters (saturating).
SEED, 4'hF, LFSR value loaded at the start of each frame.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
mode  input  1  0 = generate/append, 1 = check; sampled on the first accepted byte of each frame
s_valid  input  1  input byte valid
s_ready  output  1  input byte accepted when s_valid & s_ready
s_data  input  8  input byte
s_last  input  1  marks the final byte of the frame
m_valid  output  1  output byte valid
m_ready  input  1  sink ready
m_data  output  8  output byte
m_last  output  1  marks the final output byte of the frame
crc_ok  output  1  one-cycle pulse: check-mode frame passed
crc_err  output  1  one-cycle pulse: check-mode frame failed
crc_val  output  4  current LFSR state
frame_cnt  output  CNT_W  completed frames, saturates at all-ones
err_cnt  output  CNT_W  failed check frames, saturates at all-ones

Behaviour:
- Reset (async, active-high, clk/rst as named above):
  - state=IDLE, LFSR=SEED.
  - m_valid=0, m_data=0, m_last=0, crc_ok=0, crc_err=0.
  - frame_cnt=0, err_cnt=0, crc_val=SEED.
  - Reset mid-frame drops the frame: no append, no status pulse.
- LFSR step f(q,d), with d=data byte and q=current state:
  - n0=q3^d0^d1^d3^d7
  - n1=q0^d1^d2^d4
  - n2=q1^q3^d0^d1^d2^d5^d7
  - n3=q2^q3^d0^d2^d6^d7
- Output slice:
  - Slot is free when !m_valid | m_ready.
  - s_ready = slot free, and only in IDLE or DATA; s_ready=0 in APPEND.
  - Accepted byte appears on m_data one cycle later (latency 1).
  - m_valid, m_data and m_last stay stable while m_valid & !m_ready.
- States: IDLE, DATA, APPEND.
- IDLE, on an accepted byte:
  - Latch mode into the frame mode register.
  - Generate mode: LFSR <= f(SEED, s_data).
  - Check mode with !s_last: LFSR <= f(SEED, s_data).
  - With s_last: single-byte frame, handled as in the last-byte rules below with q=SEED.
  - Otherwise go to DATA.
- DATA, on an accepted byte without s_last: LFSR <= f(LFSR, s_data).
- Last byte in generate mode:
  - LFSR <= f(q, s_data).
  - Byte is forwarded with m_last=0; go to APPEND.
- Last byte in check mode:
  - The byte is the CRC byte and is not folded into the LFSR.
  - Pass when s_data == {4'h0, LFSR}; otherwise fail.
  - Byte is forwarded with m_last=1.
  - One cycle after acceptance: pulse crc_ok or crc_err, increment frame_cnt, increment err_cnt on fail.
  - Go to IDLE.
- APPEND:
  - When the slot is free, load m_data={4'h0, LFSR}, m_valid=1, m_last=1.
  - Increment frame_cnt, LFSR <= SEED, go to IDLE.
- Check completion also sets LFSR <= SEED.
- mode changes mid-frame are ignored until the next frame.
- Simultaneous counter saturation and increment: the counter holds at all-ones.
- crc_ok and crc_err are never both high.

Test Plan:
- Generate, frame [0x00 last] -> m: 0x00 (m_last=0), then 0x03 (m_last=1); frame_cnt=1.
- Generate, frame [0x00, 0x01 last] -> m: 0x00, 0x01, 0x0B (m_last on 0x0B); crc_val returns to 0xF.
- Check, frame [0x00, 0x03 last] -> crc_ok pulse 1 cycle, crc_err=0, err_cnt=0. Check, frame [0x00, 0x04 last] -> crc_err pulse, err_cnt=1, frame_cnt=2.
- Check, single byte [0x0F last] -> crc_ok. Check, single byte [0x1F last] -> crc_err (upper nibble nonzero).
- Backpressure: generate [0x00 last] with m_ready=0 for 5 cycles once 0x03 is presented -> m_data=0x03, m_valid=1, m_last=1 held stable; s_ready=0 throughout APPEND.
- Reset mid-frame: assert rst after byte 1 of a 3-byte generate frame -> all outputs at reset values immediately; next frame [0x01 last] -> appended CRC 0x0E.

Source files
------------

// File: rtl/crc4_frame_ctrl.sv
// Frame controller around an 8-bit-parallel CRC-4 LFSR: appends the CRC byte in
// generate mode, verifies the trailing CRC byte in check mode. 1-deep output slice.
module crc4_frame_ctrl #(
  parameter int         CNT_W = 16,
  parameter logic [3:0] SEED  = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [3:0]       crc_val,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, APPEND} state_t;

  function automatic logic [3:0] crc4_step(input logic [3:0] q, input logic [7:0] d);
    logic [3:0] n;
    n[0] = q[3] ^ d[0] ^ d[1] ^ d[3] ^ d[7];
    n[1] = q[0] ^ d[1] ^ d[2] ^ d[4];
    n[2] = q[1] ^ q[3] ^ d[0] ^ d[1] ^ d[2] ^ d[5] ^ d[7];
    n[3] = q[2] ^ q[3] ^ d[0] ^ d[2] ^ d[6] ^ d[7];
    return n;
  endfunction

  state_t     state, state_next;
  logic [3:0] lfsr, lfsr_next;
  logic       frame_mode;
  logic       slot_free, accept, cur_mode;
  logic [3:0] q_base;
  logic       load_byte, load_crc, chk_done, chk_pass, gen_done;

  assign slot_free = !m_valid || m_ready;
  assign s_ready   = slot_free && (state != APPEND);
  assign accept    = s_valid && s_ready;
  // The first byte of a frame uses the live mode input and starts from SEED.
  assign cur_mode  = (state == IDLE) ? mode : frame_mode;
  assign q_base    = (state == IDLE) ? SEED : lfsr;
  assign crc_val   = lfsr;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    load_byte  = 1'b0;
    load_crc   = 1'b0;
    chk_done   = 1'b0;
    chk_pass   = 1'b0;
    gen_done   = 1'b0;
    unique case (state)
      IDLE, DATA: begin
        if (accept) begin
          load_byte = 1'b1;
          if (!s_last) begin
            lfsr_next  = crc4_step(q_base, s_data);
            state_next = DATA;
          end else if (!cur_mode) begin
            lfsr_next  = crc4_step(q_base, s_data);
            state_next = APPEND;
          end else begin
            chk_done   = 1'b1;
            chk_pass   = (s_data == {4'h0, q_base});
            lfsr_next  = SEED;
            state_next = IDLE;
          end
        end
      end
      APPEND: begin
        if (slot_free) begin
          load_crc   = 1'b1;
          gen_done   = 1'b1;
          lfsr_next  = SEED;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= SEED;
      frame_mode <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= 8'h00;
      m_last     <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      state   <= state_next;
      lfsr    <= lfsr_next;
      crc_ok  <= chk_done && chk_pass;
      crc_err <= chk_done && !chk_pass;

      if (state == IDLE && accept) frame_mode <= mode;

      if (load_byte) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_last  <= s_last && cur_mode;
      end else if (load_crc) begin
        m_valid <= 1'b1;
        m_data  <= {4'h0, lfsr};
        m_last  <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      // Counters saturate: an increment at all-ones holds the value.
      if ((chk_done || gen_done) && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
      if (chk_done && !chk_pass && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
